alu_commit_sched: RTL and testbench

Commit-path scheduler for one ALU block. It merges the result streams of the block's execution sub-units (integer, dot8, mul/div) into the block's single commit stream using fair round-robin arbitration. A per-input starvation guard and a registered, full-throughput output stage complete the block. It sits between the sub-unit commit interfaces and the per-block commit interface that feeds the gather unit.

---
 rtl/alu_commit_sched_pkg.sv | 18 +
 rtl/alu_commit_sched_rr_pick.sv | 35 +++
 rtl/alu_commit_sched.sv | 131 +++++++++++++
 tb/tb_alu_commit_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_commit_sched_pkg.sv
// Shared constants for the ALU commit-path scheduler: default stream count,
// index/counter widths, sub-unit stream indices and the pointer wrap helper.
package alu_commit_sched_pkg;

   localparam int ALU_RSP_NUM       = 3;
   localparam int ALU_RSP_MAX_WAIT  = 7;
   localparam int ALU_RSP_IDX_BITS  = $clog2(ALU_RSP_NUM);
   localparam int ALU_RSP_WAIT_BITS = $clog2(ALU_RSP_MAX_WAIT + 1);

   localparam int ALU_RSP_INT  = 0;
   localparam int ALU_RSP_DOT8 = 1;
   localparam int ALU_RSP_MDV  = 2;

   function automatic int alu_rsp_next_ptr(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/alu_commit_sched_rr_pick.sv
// Rotating priority encoder: first requester at or after start, searching
// upward modulo N. Purely combinational.
module alu_rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   int             j;
   logic [N-1:0]   cand;

   // Walk from the farthest candidate back to start so the nearest one wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j    = (int'(start) + k) % N;
         cand = N'(1) << j;
         if (|(req & cand)) begin
            grant = cand;
            idx   = IW'(j);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_commit_sched.sv
// Commit-path scheduler: merges the sub-unit result streams into one registered
// commit stream with round-robin arbitration and a per-input starvation guard.
module alu_commit_sched
   import alu_commit_sched_pkg::*;
#(
   parameter int NUM_INPUTS = ALU_RSP_NUM,
   parameter int DATAW      = 64,
   parameter int MAX_WAIT   = ALU_RSP_MAX_WAIT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_INPUTS-1:0]         valid_in,
   output logic [NUM_INPUTS-1:0]         ready_in,
   input  logic [NUM_INPUTS*DATAW-1:0]   data_in,
   output logic                          valid_out,
   input  logic                          ready_out,
   output logic [DATAW-1:0]              data_out,
   output logic [$clog2(NUM_INPUTS)-1:0] sel_out
);

   localparam int IDX_BITS  = $clog2(NUM_INPUTS);
   localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_BITS-1:0] WAIT_SAT = WAIT_BITS'(MAX_WAIT);

   logic [IDX_BITS-1:0]   rr_ptr;
   logic [WAIT_BITS-1:0]  wait_cnt [NUM_INPUTS];

   logic                  accept;
   logic [NUM_INPUTS-1:0] starving;
   logic                  starve_any;
   logic [IDX_BITS-1:0]   starve_idx;

   logic [NUM_INPUTS-1:0] rr_grant;
   logic [IDX_BITS-1:0]   rr_idx;
   logic                  rr_any;

   logic [NUM_INPUTS-1:0] grant;
   logic [IDX_BITS-1:0]   grant_idx;
   logic                  grant_any;
   logic [DATAW-1:0]      grant_data;

   logic [NUM_INPUTS-1:0] fire;
   logic                  fire_any;

   alu_rr_pick #(
      .N  (NUM_INPUTS),
      .IW (IDX_BITS)
   ) u_rr_pick (
      .req   (valid_in),
      .start (rr_ptr),
      .grant (rr_grant),
      .idx   (rr_idx),
      .any   (rr_any)
   );

   always_comb begin
      starving = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         starving[i] = valid_in[i] & (wait_cnt[i] == WAIT_SAT);
      end
   end

   // Lowest starving index overrides the round-robin choice.
   always_comb begin
      starve_any = 1'b0;
      starve_idx = '0;
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
         if (starving[i]) begin
            starve_any = 1'b1;
            starve_idx = IDX_BITS'(i);
         end
      end
   end

   always_comb begin
      if (starve_any) begin
         grant     = NUM_INPUTS'(1) << starve_idx;
         grant_idx = starve_idx;
         grant_any = 1'b1;
      end else begin
         grant     = rr_grant;
         grant_idx = rr_idx;
         grant_any = rr_any;
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant[i]) begin
            grant_data = data_in[i*DATAW +: DATAW];
         end
      end
   end

   assign accept   = ~valid_out | ready_out;
   assign ready_in = (accept & ~reset) ? grant : '0;
   assign fire     = valid_in & ready_in;
   assign fire_any = |fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         sel_out   <= '0;
         rr_ptr    <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            wait_cnt[i] <= '0;
         end
      end else begin
         if (fire_any && grant_any) begin
            valid_out <= 1'b1;
            data_out  <= grant_data;
            sel_out   <= grant_idx;
            rr_ptr    <= IDX_BITS'(alu_rsp_next_ptr(int'(grant_idx), NUM_INPUTS));
         end else if (accept) begin
            valid_out <= 1'b0;
         end

         // Only rounds actually lost to another input count; stalls do not.
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (fire[i] || !valid_in[i]) begin
               wait_cnt[i] <= '0;
            end else if (fire_any && wait_cnt[i] != WAIT_SAT) begin
               wait_cnt[i] <= wait_cnt[i] + WAIT_BITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_commit_sched.sv
// Bench for alu_commit_sched: directed vector table, starvation sequences on a
// MAX_WAIT=2 instance, and randomized traffic against a behavioural model.
module tb_alu_commit_sched;

   localparam int S_MAXW = 2;

   logic         clk;
   int           n_checks;
   int           n_errors;

   // main instance (MAX_WAIT = 7)
   logic         rst;
   logic [2:0]   valid_in;
   logic [2:0]   ready_in;
   logic [191:0] data_in;
   logic         valid_out;
   logic         ready_out;
   logic [63:0]  data_out;
   logic [1:0]   sel_out;

   // starvation instance (MAX_WAIT = 2)
   logic         s_rst;
   logic [2:0]   s_valid_in;
   logic [2:0]   s_ready_in;
   logic [191:0] s_data_in;
   logic         s_valid_out;
   logic         s_ready_out;
   logic [63:0]  s_data_out;
   logic [1:0]   s_sel_out;

   alu_commit_sched #(.NUM_INPUTS(3), .DATAW(64), .MAX_WAIT(7)) dut (
      .clk       (clk),
      .reset     (rst),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out),
      .sel_out   (sel_out)
   );

   alu_commit_sched #(.NUM_INPUTS(3), .DATAW(64), .MAX_WAIT(S_MAXW)) dut_s (
      .clk       (clk),
      .reset     (s_rst),
      .valid_in  (s_valid_in),
      .ready_in  (s_ready_in),
      .data_in   (s_data_in),
      .valid_out (s_valid_out),
      .ready_out (s_ready_out),
      .data_out  (s_data_out),
      .sel_out   (s_sel_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  v;
      logic        ro;
      logic [2:0]  rdy;
      logic        vo;
      logic [1:0]  sel;
      logic [63:0] d;
      int          w0;
      int          w1;
      int          w2;
   } vec_t;

   vec_t tbl [15];

   // behavioural model state for the randomized phase
   int          m_w [3];
   int          m_rr;
   bit          m_vo;
   logic [63:0] m_data;
   int          m_sel;
   bit [2:0]    m_fired;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic [2:0] v);
      int g;
      g = -1;
      for (int i = 0; i < 3; i++)
         if (g < 0 && v[i] && m_w[i] == S_MAXW) g = i;
      for (int k = 0; k < 3; k++)
         if (g < 0 && v[(m_rr + k) % 3]) g = (m_rr + k) % 3;
      return g;
   endfunction

   function automatic logic [2:0] model_ready(input logic [2:0] v, input logic ro, input logic r);
      int g;
      g = model_grant(v);
      if (r || g < 0 || !(!m_vo || ro)) return 3'b000;
      return 3'(1 << g);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_w[i] = 0;
      m_rr = 0; m_vo = 0; m_data = '0; m_sel = 0; m_fired = '0;
   endtask

   task automatic model_step(input logic [2:0] v, input logic ro, input logic r, input logic [191:0] d);
      int g;
      int fg;
      if (r) begin
         model_reset();
         return;
      end
      g  = model_grant(v);
      fg = ((!m_vo || ro) && g >= 0) ? g : -1;
      m_fired = '0;
      if (fg >= 0) begin
         m_vo = 1; m_data = d[fg*64 +: 64]; m_sel = fg; m_rr = (fg + 1) % 3;
         m_fired[fg] = 1'b1;
      end else if (!m_vo || ro) begin
         m_vo = 0;
      end
      for (int i = 0; i < 3; i++) begin
         if (i == fg || !v[i]) m_w[i] = 0;
         else if (fg >= 0 && m_w[i] < S_MAXW) m_w[i] = m_w[i] + 1;
      end
   endtask

   task automatic s_cycle(input string name, input logic [2:0] exp_rdy);
      #1;
      chk(name, 64'(s_ready_in), 64'(exp_rdy));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      tbl[0]  = '{3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 64'hAA, 0, 0, 0};
      tbl[1]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 64'hAA, 0, 0, 0};
      tbl[2]  = '{3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 64'h33, 0, 0, 0};
      tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 64'h55, 0, 1, 1};
      tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 64'hAA, 1, 0, 2};
      tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 64'h33, 2, 1, 0};
      tbl[6]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 64'h55, 0, 2, 1};
      tbl[7]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 64'hAA, 1, 0, 2};
      tbl[8]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 64'h33, 2, 1, 0};
      tbl[9]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 64'h55, 0, 2, 1};
      tbl[10] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 64'h55, 0, 2, 1};
      tbl[11] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 64'h55, 0, 2, 1};
      tbl[12] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 64'h55, 0, 2, 1};
      tbl[13] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 64'h55, 0, 2, 1};
      tbl[14] = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 64'hAA, 1, 0, 2};

      rst       = 1'b1;
      valid_in  = 3'b111;
      ready_out = 1'b1;
      data_in   = {64'h33, 64'hAA, 64'h55};
      s_rst       = 1'b1;
      s_valid_in  = 3'b000;
      s_ready_out = 1'b1;
      s_data_in   = {64'h102, 64'h101, 64'h100};

      // reset held for two cycles with requests pending
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("reset_ready_in", 64'(ready_in), 64'd0);
         chk("reset_valid_out", 64'(valid_out), 64'd0);
         chk("reset_sel_out", 64'(sel_out), 64'd0);
         chk("reset_data_out", data_out, 64'd0);
      end
      rst = 1'b0;

      for (int r = 0; r < 15; r++) begin
         valid_in  = tbl[r].v;
         ready_out = tbl[r].ro;
         #1;
         chk($sformatf("tbl%0d_ready_in", r), 64'(ready_in), 64'(tbl[r].rdy));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid_out", r), 64'(valid_out), 64'(tbl[r].vo));
         chk($sformatf("tbl%0d_sel_out", r), 64'(sel_out), 64'(tbl[r].sel));
         chk($sformatf("tbl%0d_data_out", r), data_out, tbl[r].d);
         chk($sformatf("tbl%0d_wait0", r), 64'(dut.wait_cnt[0]), 64'(tbl[r].w0));
         chk($sformatf("tbl%0d_wait1", r), 64'(dut.wait_cnt[1]), 64'(tbl[r].w1));
         chk($sformatf("tbl%0d_wait2", r), 64'(dut.wait_cnt[2]), 64'(tbl[r].w2));
      end

      // mid-stream reset while the output is stalled
      ready_out = 1'b0;
      valid_in  = 3'b111;
      rst       = 1'b1;
      #1;
      chk("midrst_ready_in", 64'(ready_in), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid_out", 64'(valid_out), 64'd0);
      chk("midrst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      chk("midrst_data_out", data_out, 64'd0);
      rst       = 1'b0;
      ready_out = 1'b1;
      #1;
      chk("postrst_ready_in", 64'(ready_in), 64'b001);
      @(posedge clk);
      @(negedge clk);
      chk("postrst_sel_out", 64'(sel_out), 64'd0);
      chk("postrst_data_out", data_out, 64'h55);
      valid_in = 3'b000;

      // single starving input with round-robin pinned to input 0
      s_rst = 1'b0;
      force dut_s.rr_ptr = 2'd0;
      s_valid_in = 3'b101;
      s_cycle("starve_c1_ready", 3'b001);
      s_cycle("starve_c2_ready", 3'b001);
      chk("starve_w2_sat", 64'(dut_s.wait_cnt[2]), 64'(S_MAXW));
      s_cycle("starve_c3_ready", 3'b100);
      chk("starve_w2_clear", 64'(dut_s.wait_cnt[2]), 64'd0);
      chk("starve_sel_out", 64'(s_sel_out), 64'd2);
      chk("starve_data_out", s_data_out, 64'h102);

      // inputs 0 and 2 saturate together with round-robin pinned to input 1
      s_valid_in = 3'b000;
      s_cycle("idle_ready", 3'b000);
      force dut_s.rr_ptr = 2'd1;
      s_valid_in = 3'b111;
      s_cycle("simul_c1_ready", 3'b010);
      s_cycle("simul_c2_ready", 3'b010);
      chk("simul_w0_sat", 64'(dut_s.wait_cnt[0]), 64'(S_MAXW));
      chk("simul_w2_sat", 64'(dut_s.wait_cnt[2]), 64'(S_MAXW));
      s_cycle("simul_c3_ready", 3'b001);
      chk("simul_w2_held", 64'(dut_s.wait_cnt[2]), 64'(S_MAXW));
      chk("simul_c3_sel", 64'(s_sel_out), 64'd0);
      s_cycle("simul_c4_ready", 3'b100);
      chk("simul_c4_sel", 64'(s_sel_out), 64'd2);
      chk("simul_w2_clear", 64'(dut_s.wait_cnt[2]), 64'd0);
      release dut_s.rr_ptr;

      // randomized traffic against the behavioural model
      s_rst = 1'b1;
      s_valid_in = 3'b000;
      @(posedge clk);
      @(negedge clk);
      s_rst = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic [2:0] er;
         for (int i = 0; i < 3; i++) begin
            if (!(s_valid_in[i] && !m_fired[i])) begin
               s_valid_in[i] = ($urandom_range(99) < 60);
               s_data_in[i*64 +: 64] = {$urandom, $urandom};
            end
         end
         s_ready_out = ($urandom_range(99) < 70);
         s_rst = ($urandom_range(199) == 0);
         #1;
         er = model_ready(s_valid_in, s_ready_out, s_rst);
         chk("rnd_ready_in", 64'(s_ready_in), 64'(er));
         @(posedge clk);
         model_step(s_valid_in, s_ready_out, s_rst, s_data_in);
         if (s_rst) m_fired = '0;
         @(negedge clk);
         chk("rnd_valid_out", 64'(s_valid_out), 64'(m_vo));
         chk("rnd_sel_out", 64'(s_sel_out), 64'(m_sel));
         chk("rnd_data_out", s_data_out, m_data);
         for (int i = 0; i < 3; i++)
            chk($sformatf("rnd_wait%0d", i), 64'(dut_s.wait_cnt[i]), 64'(m_w[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
